// File: rtl/mdr_mem_ctrl_if.sv
// Memory data register bus bundle: control-unit strobes, internal bus, and memory port.
// The master side drives commands and memory responses; the slave side is the MDR.
interface mdr_mem_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              enable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] BusData;
    logic [DATA_W-1:0] Mdatain;
    logic              mem_ack;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [DATA_W-1:0] Mdataout;
    logic [DATA_W-1:0] Q;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output enable, read, write, BusData, Mdatain, mem_ack,
        input  mem_rd_req, mem_wr_req, Mdataout, Q, busy, done, err
    );

    modport slave (
        input  enable, read, write, BusData, Mdatain, mem_ack,
        output mem_rd_req, mem_wr_req, Mdataout, Q, busy, done, err
    );
endinterface

// File: rtl/mdr_mem_ctrl.sv
// Memory data register with a req/ack handshake to a variable-latency memory.
// Define MDR_TIMEOUT_EN to abort unacknowledged requests after TIMEOUT_CYC cycles.
module mdr_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic         clk,
    input  logic         clr,
    mdr_mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] q_r;
    logic              done_r;
    logic              err_r;

    logic load_bus;
    logic load_mem;
    logic set_done;
    logic start_cmd;
    logic timeout;
    logic timeout_hit;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("mdr_mem_ctrl: TIMEOUT_CYC must be at least 2");
    end

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_cnt;

    // Held at zero in IDLE so every wait starts counting from zero.
    always_ff @(posedge clk) begin
        if (clr || state == IDLE) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            q_r    <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_r <= set_done;
            if (load_bus) begin
                q_r <= bus.BusData;
            end else if (load_mem) begin
                q_r <= bus.Mdatain;
            end
            if (timeout_hit) begin
                err_r <= 1'b1;
            end else if (start_cmd) begin
                err_r <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        load_bus    = 1'b0;
        load_mem    = 1'b0;
        set_done    = 1'b0;
        start_cmd   = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.enable && bus.read) begin
                    state_nxt = RD_WAIT;
                    start_cmd = 1'b1;
                end else if (bus.enable) begin
                    load_bus = 1'b1;
                end else if (bus.write) begin
                    state_nxt = WR_WAIT;
                    start_cmd = 1'b1;
                end
            end
            RD_WAIT: begin
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                    load_mem  = 1'b1;
                    set_done  = 1'b1;
                end else if (timeout) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            WR_WAIT: begin
                if (bus.mem_ack) begin
                    state_nxt = IDLE;
                    set_done  = 1'b1;
                end else if (timeout) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd_req = (state == RD_WAIT);
        bus.mem_wr_req = (state == WR_WAIT);
        bus.busy       = (state == RD_WAIT) || (state == WR_WAIT);
    end

    assign bus.Q        = q_r;
    assign bus.Mdataout = q_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;
endmodule
